// File: rtl/mac_pkg.sv
// Shared types and default sizing for the product accumulator.
// State encoding, default widths and the term-counter width derivation.
package mac_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 10;
    localparam int DEF_LEN    = 8;

    // Counter must represent every value from 0 up to and including len.
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_acc_add.sv
// Combinational accumulate step: ACC_W+1 adder with a sticky overflow flag.
// Defining SATURATE_EN clamps the sum to all-ones once overflow has occurred.
module acc_add
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              ovf_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W:0] sum_full;

    assign sum_full = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
    assign ovf_o    = sum_full[ACC_W] | ovf_i;

    always_comb begin
        sum_o = sum_full[ACC_W-1:0];
`ifdef SATURATE_EN
        // Once the vector has overflowed it stays pinned at full scale.
        if (ovf_o) begin
            sum_o = {ACC_W{1'b1}};
        end
`else
        sum_o = sum_full[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums a stream of unsigned products into a dot-product result with valid/ready
// on both sides. Saturating behaviour is selected with SATURATE_EN (see acc_add).
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int LEN    = DEF_LEN,
    parameter int CNT_W  = cnt_width(LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovfo_q, ovfo_d;

    logic              beat;
    logic              close;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = ovfo_q;

    assign beat  = in_valid && in_ready;
    assign close = in_last || (cnt_q == LAST_CNT);

    acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_acc_add (
        .acc_i  (acc_q),
        .prod_i (in_prod),
        .ovf_i  (ovf_q),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            sum_q   <= '0;
            count_q <= '0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovfo_q  <= ovfo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovfo_d  = ovfo_q;

        case (state_q)
            ST_ACC: begin
                if (beat) begin
                    if (close) begin
                        // Result registers capture the total including this beat.
                        state_d = ST_DONE;
                        sum_d   = add_sum;
                        count_d = cnt_q + CNT_ONE;
                        ovfo_d  = add_ovf;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        acc_d = add_sum;
                        cnt_d = cnt_q + CNT_ONE;
                        ovf_d = add_ovf;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized bench for product_accumulator with a sum-of-vector model.
module tb_product_accumulator;

    localparam int ACC_W = 10;
    localparam int LEN   = 8;
    localparam int MAXV  = (1 << ACC_W) - 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_prod;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [3:0] out_count;
    logic       out_ovf;

    int checks = 0;
    int errors = 0;

    product_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a vector's result depends only on the list of its products.
    function automatic int model_sum(input int total);
`ifdef SATURATE_EN
        return (total > MAXV) ? MAXV : total;
`else
        return total % (MAXV + 1);
`endif
    endfunction

    task automatic beat(input int p, input bit last);
        in_valid = 1'b1;
        in_prod  = 8'(p);
        in_last  = last;
        check("beat_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int total, input int n);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, out_sum, model_sum(total));
        check({tag, "_count"}, out_count, n);
        check({tag, "_ovf"}, out_ovf, (total > MAXV) ? 1 : 0);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_release_ready", in_ready, 1);
    endtask

    initial begin
        int q[$];
        int total;
        int len;
        bit use_last;
        int waited;
        logic [9:0] held;

        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_count", out_count, 0);
        check("rst_ovf", out_ovf, 0);
        rst = 1'b0;
        check("rst_ready", in_ready, 1);

        // Four beats with early close.
        beat(6, 0); beat(66, 0); beat(15, 0); beat(0, 1);
        expect_result("t1", 87, 4);
        release_result();

        // Auto-close at LEN with overflow.
        for (int i = 0; i < LEN; i++) begin
            if (i == LEN - 1) check("t2_not_yet", out_valid, 0);
            beat(225, 0);
        end
        expect_result("t2", 8 * 225, 8);
        release_result();

        // Back-pressure: DONE ignores incoming beats.
        beat(40, 1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_prod = 8'd50;
            check("t3_ready_low", in_ready, 0);
            check("t3_sum_hold", out_sum, 40);
            check("t3_valid_hold", out_valid, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        release_result();
        beat(7, 1);
        expect_result("t3_next", 7, 1);
        release_result();

        // in_valid gaps hold the accumulation.
        beat(10, 0);
        in_prod = 8'd99; @(negedge clk);
        in_prod = 8'd77; @(negedge clk);
        beat(20, 0); beat(30, 1);
        expect_result("t4", 60, 3);
        release_result();

        // Reset mid-vector discards the partial sum.
        beat(100, 0); beat(100, 0); beat(100, 0);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        check("t5_valid", out_valid, 0);
        check("t5_sum", out_sum, 0);
        check("t5_count", out_count, 0);
        check("t5_ovf", out_ovf, 0);
        check("t5_ready", in_ready, 1);
        beat(5, 0); beat(5, 1);
        expect_result("t5", 10, 2);
        release_result();

        // Back-to-back vectors with out_ready held high: one bubble.
        beat(200, 1);
        expect_result("t6a", 200, 1);
        out_ready = 1'b1;
        in_valid = 1'b1; in_prod = 8'd1; in_last = 1'b1;
        check("t6_bubble", in_ready, 0);
        @(negedge clk);
        check("t6_ready", in_ready, 1);
        check("t6_valid_gap", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        expect_result("t6b", 1, 1);
        @(negedge clk);
        out_ready = 1'b0;
        check("t6_done", out_valid, 0);

        // Randomized vectors against the model.
        for (int v = 0; v < 30; v++) begin
            len = $urandom_range(1, LEN);
            use_last = (len < LEN) ? 1'b1 : 1'($urandom_range(0, 1));
            q.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_prod = 8'($urandom);
                    @(negedge clk);
                end
                q.push_back($urandom_range(0, 255));
                beat(q[i], use_last && (i == len - 1));
            end
            total = 0;
            foreach (q[i]) total += q[i];
            waited = 0;
            while (!out_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("rnd_latency", waited, 0);
            held = out_sum;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            check("rnd_hold", out_sum, held);
            expect_result("rnd", total, len);
            release_result();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
